// File: rtl/cram_pkg.sv
// Shared types and sizing helpers for the CRAM scan-chain loader.
package cram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_CHAIN_LEN = 1024;
  localparam int DEF_WORD_W    = 8;
  localparam int DEF_TIMEOUT   = 255;

  // Bits needed for a counter that must be able to hold max_val itself.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cram_serializer.sv
// Word-to-bit serializer: WORD_W shift register plus occupancy, LSB first.
module cram_serializer
  import cram_pkg::*;
#(
  parameter  int WORD_W = DEF_WORD_W,
  localparam int OW     = cnt_w(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              shift_en_i,
  input  logic              need_i,
  input  logic              word_valid_i,
  input  logic [WORD_W-1:0] word_data_i,
  output logic              word_ready_o,
  output logic              config_en_o,
  output logic              config_data_o,
  output logic [OW-1:0]     occ_o
);

  logic [OW-1:0]     occ_q, occ_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic              shift, accept;

  // Handshake: a word transfers on a cycle where word_valid_i and word_ready_o
  // are both high; ready never depends on valid, and opens while the last bit
  // of the previous word is leaving so consecutive words shift without gaps.
  assign shift         = shift_en_i && (occ_q != '0);
  assign word_ready_o  = shift_en_i && need_i && ((occ_q == '0) || (occ_q == OW'(1)));
  assign accept        = word_ready_o && word_valid_i;
  assign config_en_o   = shift;
  assign config_data_o = shift && sr_q[0];
  assign occ_o         = occ_q;

  always_comb begin
    occ_d = occ_q;
    sr_d  = sr_q;
    if (flush_i) begin
      occ_d = '0;
      sr_d  = '0;
    end else begin
      if (shift) begin
        occ_d = occ_q - OW'(1);
        sr_d  = sr_q >> 1;
      end
      if (accept) begin
        occ_d = OW'(WORD_W);
        sr_d  = word_data_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
      sr_q  <= '0;
    end else begin
      occ_q <= occ_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/cram_loader.sv
// CRAM load sequencer: clears the chain, shifts CHAIN_LEN bits, then releases the fabric.
module cram_loader
  import cram_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              cram_nrst,
  output logic              config_en,
  output logic              config_data,
  output logic              le_nrst,
  output logic              le_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BW = cnt_w(CHAIN_LEN);
  localparam int SW = cnt_w(TIMEOUT);
  localparam int OW = cnt_w(WORD_W);

  state_t        state_q, state_d;
  logic [BW-1:0] bit_cnt_q;
  logic [SW-1:0] starve_q;
  logic [OW-1:0] occ;
  logic          cram_nrst_q, cram_nrst_d, le_nrst_q, le_nrst_d, le_en_q, le_en_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          in_load, kill, accept, starving, timeout, last_bit, need;

  assign in_load  = (state_q == CLEAR) || (state_q == SHIFT);
  assign kill     = abort && in_load;
  assign accept   = word_ready && word_valid;
  assign starving = (state_q == SHIFT) && (occ == '0) && !word_valid;
  assign timeout  = starving && (starve_q == SW'(TIMEOUT - 1));
  assign last_bit = config_en && (bit_cnt_q == BW'(CHAIN_LEN - 1));
  // Stop asking for words once shifted plus buffered bits cover the chain.
  assign need     = (32'(bit_cnt_q) + 32'(occ)) < 32'(CHAIN_LEN);

  cram_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (state_q != SHIFT),
    .shift_en_i   ((state_q == SHIFT) && !abort),
    .need_i       (need),
    .word_valid_i (word_valid),
    .word_data_i  (word_data),
    .word_ready_o (word_ready),
    .config_en_o  (config_en),
    .config_data_o(config_data),
    .occ_o        (occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cram_nrst_q <= 1'b1;
      le_nrst_q   <= 1'b0;
      le_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cram_nrst_q <= cram_nrst_d;
      le_nrst_q   <= le_nrst_d;
      le_en_q     <= le_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = kill ? IDLE : SHIFT;
      SHIFT: begin
        if (kill || timeout) state_d = IDLE;
        else if (last_bit)   state_d = DONE;
      end
      DONE:    if (start) state_d = CLEAR;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    cram_nrst_d = (state_d != CLEAR);
    busy_d      = (state_d == CLEAR) || (state_d == SHIFT);
    done_d      = (state_d == DONE);
    le_nrst_d   = (state_d == DONE);
    le_en_d     = (state_d == DONE);
    err_d       = err_q;
    if (start && !in_load) err_d = 1'b0;
    if (kill || timeout)   err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      starve_q  <= '0;
    end else if (state_q == CLEAR) begin
      bit_cnt_q <= '0;
      starve_q  <= '0;
    end else if (state_q == SHIFT) begin
      if (config_en) bit_cnt_q <= bit_cnt_q + BW'(1);
      if (accept)        starve_q <= '0;
      else if (starving) starve_q <= starve_q + SW'(1);
    end
  end

  assign cram_nrst = cram_nrst_q;
  assign le_nrst   = le_nrst_q;
  assign le_en     = le_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
